// File: rtl/logicnets_seq_pkg.sv
// Shared constants, state encoding and width helper for time-multiplexed
// LogicNets layer sequencers.
package logicnets_seq_pkg;

  localparam int FANIN = 6;
  localparam int TT_W  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of one fan-in index; a 1-bit input vector still needs a 1-bit index.
  function automatic int idx_width(input int in_width);
    return (in_width > 1) ? $clog2(in_width) : 1;
  endfunction

endpackage

// File: rtl/logicnets_lut_mux.sv
// Combinational 6-input truth-table neuron: gathers six activation bits
// through the fan-in indices and selects the matching truth-table bit.
module logicnets_lut_mux
  import logicnets_seq_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int IW       = idx_width(IN_WIDTH)
) (
  input  logic [IN_WIDTH-1:0] in_vec,
  input  logic [FANIN*IW-1:0] idx,
  input  logic [TT_W-1:0]     tt,
  output logic                out
);

  logic [FANIN-1:0] addr;
  logic [IW-1:0]    sel;

  // NOTE: every variable driven here gets a default before the loop, so no
  // path leaves it holding a previous value (which would infer a latch).
  always_comb begin
    addr = '0;
    sel  = '0;
    for (int j = 0; j < FANIN; j++) begin
      sel = idx[j*IW +: IW];
      // Out-of-range indices fall back to activation bit 0.
      addr[j] = (int'(sel) < IN_WIDTH) ? in_vec[sel] : in_vec[0];
    end
    out = tt[addr];
  end

endmodule

// File: rtl/logicnets_layer_sequencer.sv
// One LogicNets layer evaluated a neuron per clock through a shared LUT mux,
// with per-neuron programmable truth tables and fan-in indices.
module logicnets_layer_sequencer
  import logicnets_seq_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int NEURONS  = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cfg_we,
  input  logic [$clog2(NEURONS)-1:0]             cfg_addr,
  input  logic [TT_W-1:0]                        cfg_tt,
  input  logic [FANIN*idx_width(IN_WIDTH)-1:0]   cfg_idx,
  output logic                                   cfg_drop,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [IN_WIDTH-1:0]                    in_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [NEURONS-1:0]                     out_data,
  output logic                                   busy
);

  localparam int IW = idx_width(IN_WIDTH);
  localparam int AW = $clog2(NEURONS);
  localparam logic [AW-1:0] LAST = AW'(NEURONS - 1);

  state_t state, state_next;

  logic [AW-1:0]       cnt;
  logic [IN_WIDTH-1:0] in_q;
  logic                lut_bit;

  logic [TT_W-1:0]     tt_mem  [NEURONS];
  logic [FANIN*IW-1:0] idx_mem [NEURONS];

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)      state_next = EVAL;
      EVAL:    if (cnt == LAST)   state_next = DONE;
      DONE:    if (out_ready)     state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
  end

  // Configuration store; writes commit only while idle.
  // NOTE: the tables are reset explicitly because a reset must leave every
  // neuron at a known all-zero configuration, not just the control path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NEURONS; n++) begin
        tt_mem[n]  <= '0;
        idx_mem[n] <= '0;
      end
      cfg_drop <= 1'b0;
    end else begin
      cfg_drop <= cfg_we && (state != IDLE);
      if (cfg_we && (state == IDLE) && (int'(cfg_addr) < NEURONS)) begin
        tt_mem[cfg_addr]  <= cfg_tt;
        idx_mem[cfg_addr] <= cfg_idx;
      end
    end
  end

  logicnets_lut_mux #(
    .IN_WIDTH (IN_WIDTH),
    .IW       (IW)
  ) u_lut_mux (
    .in_vec (in_q),
    .idx    (idx_mem[cnt]),
    .tt     (tt_mem[cnt]),
    .out    (lut_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          in_q     <= in_data;
          out_data <= '0;
          cnt      <= '0;
        end
        EVAL: begin
          out_data[cnt] <= lut_bit;
          if (cnt == LAST) begin
            cnt       <= '0;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logicnets_layer_sequencer.sv
// Directed scoreboard bench for logicnets_layer_sequencer at IN_WIDTH=8,
// NEURONS=4: expected vectors queue at issue, a monitor pops on handshake.
module tb_logicnets_layer_sequencer;

  localparam int IN_WIDTH = 8;
  localparam int NEURONS  = 4;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [63:0] cfg_tt;
  logic [17:0] cfg_idx;
  logic        cfg_drop;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q [$];

  logicnets_layer_sequencer #(
    .IN_WIDTH (IN_WIDTH),
    .NEURONS  (NEURONS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_tt    (cfg_tt),
    .cfg_idx   (cfg_idx),
    .cfg_drop  (cfg_drop),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares each presented result at the handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", out_valid, 1'b0);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [63:0] tt, input logic [17:0] idx);
    cfg_we = 1'b1; cfg_addr = a; cfg_tt = tt; cfg_idx = idx;
    tick();
    cfg_we = 1'b0;
    check("cfg_drop_idle", cfg_drop, 1'b0);
  endtask

  // mode 0: plain; 1: attempt neuron0 write during EVAL;
  // 2: write neuron2 (all-ones table) in the accept cycle.
  task automatic run_vec(input logic [7:0] d, input logic [3:0] exp, input int hold, input int mode);
    int cycles;
    exp_q.push_back(exp);
    out_ready = 1'b0;
    check("in_ready_before_accept", in_ready, 1'b1);
    in_data = d; in_valid = 1'b1;
    if (mode == 2) begin
      cfg_we = 1'b1; cfg_addr = 2'd2; cfg_tt = '1; cfg_idx = '0;
    end
    tick();                                   // edge E0
    in_valid = 1'b0; cfg_we = 1'b0;
    check("in_ready_eval", in_ready, 1'b0);
    check("busy_eval", busy, 1'b1);
    cycles = 0;
    if (mode == 2) check("cfg_drop_same_cycle", cfg_drop, 1'b0);
    if (mode == 1) begin
      cfg_we = 1'b1; cfg_addr = 2'd0; cfg_tt = '0; cfg_idx = '0;
      tick(); cycles++;
      cfg_we = 1'b0;
      check("cfg_drop_pulse", cfg_drop, 1'b1);
      tick(); cycles++;
      check("cfg_drop_single", cfg_drop, 1'b0);
    end
    while (!out_valid && cycles < 50) begin
      tick(); cycles++;
    end
    check("latency", cycles, NEURONS);
    for (int i = 0; i < hold; i++) begin
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_out_data", out_data, exp);
      check("bp_busy", busy, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      in_valid = 1'b1; in_data = 8'hAA;
      tick();
    end
    in_valid = 1'b0;
    check("in_ready_done", in_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("in_ready_return", in_ready, 1'b1);
    check("out_valid_drop", out_valid, 1'b0);
    check("busy_idle", busy, 1'b0);
    check("out_data_hold", out_data, exp);
  endtask

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_tt = '0; cfg_idx = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 4'h0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_cfg_drop", cfg_drop, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();

    cfg_write(2'd0, 64'hAAAA_AAAA_AAAA_AAAA, {6{3'd3}});
    cfg_write(2'd1, 64'h8000_0000_0000_0000, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});

    run_vec(8'h3F, 4'b0011, 0, 0);
    run_vec(8'h17, 4'b0000, 10, 0);
    run_vec(8'h3F, 4'b0011, 0, 1);
    run_vec(8'h08, 4'b0001, 0, 0);
    run_vec(8'h00, 4'b0100, 0, 2);

    // Abort an evaluation after edge E2.
    in_data = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_data", out_data, 4'h0);
    tick(); tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_valid", out_valid, 1'b0);
    end
    out_ready = 1'b0;
    run_vec(8'hFF, 4'h0, 0, 0);

    tick(); tick();
    check("scoreboard_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
